// File: rtl/mux_sel_sequencer.sv
// Timed scan sequencer for a 5-to-1 select mux: steps s2..s0, samples M per slot.
// Optional manual source selection via `define MUX_SEQ_MANUAL_EN.
module mux_sel_sequencer #(
  parameter int DATA_WIDTH = 3,
  parameter int DWELL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [DATA_WIDTH-1:0] m_in,
`ifdef MUX_SEQ_MANUAL_EN
  input  logic                  mode,
  input  logic [2:0]            man_sel,
`endif
  output logic                  s2,
  output logic                  s1,
  output logic                  s0,
  output logic [DATA_WIDTH-1:0] m_out,
  output logic [2:0]            m_idx,
  output logic                  m_valid,
  output logic                  scan_done
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_nxt;
  logic [DWELL_W-1:0]    r_cnt;
  logic [DWELL_W-1:0]    w_cnt_nxt;
  logic [2:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_m_out;
  logic [2:0]            r_m_idx;
  logic                  r_m_valid;
  logic                  r_scan_done;

  logic                  w_take;
  logic [DWELL_W-1:0]    w_dwell_ld;
  logic [2:0]            w_idx_inc;
  logic [2:0]            w_idx_adv;
  logic [2:0]            w_idx_entry;

  // A zero dwell still needs one settle cycle before capture.
  assign w_dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_idx_inc  = (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;

`ifdef MUX_SEQ_MANUAL_EN
  logic [2:0] w_man;
  assign w_man       = (man_sel > 3'd4) ? 3'd4 : man_sel;
  assign w_idx_adv   = mode ? w_man : w_idx_inc;
  assign w_idx_entry = mode ? w_man : r_idx;
`else
  assign w_idx_adv   = w_idx_inc;
  assign w_idx_entry = r_idx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = w_dwell_ld;
          w_idx_nxt   = w_idx_entry;
        end
      end
      SETTLE: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= DWELL_W'(1)) begin
          w_state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        w_take    = 1'b1;
        w_idx_nxt = w_idx_adv;
        if (en) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = w_dwell_ld;
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 3'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_sel       <= 3'd0;
      r_m_out     <= '0;
      r_m_idx     <= 3'd0;
      r_m_valid   <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      // Select encoding equals the source index (U..Y = 0..4).
      r_sel       <= w_idx_nxt;
      r_m_valid   <= w_take;
      r_scan_done <= w_take && (r_idx == 3'd4);
      if (w_take) begin
        r_m_out <= m_in;
        r_m_idx <= r_idx;
      end
    end
  end

  assign {s2, s1, s0} = r_sel;
  assign m_out        = r_m_out;
  assign m_idx        = r_m_idx;
  assign m_valid      = r_m_valid;
  assign scan_done    = r_scan_done;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed scoreboard bench for mux_sel_sequencer with a model 5-to-1 mux.
// Expected strobes (cycle, data, index, done) are queued and checked on arrival.
module tb_mux_sel_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] dwell;
  logic [2:0] m_in;
  logic       mode;
  logic [2:0] man_sel;
  logic       s2, s1, s0;
  logic [2:0] m_out;
  logic [2:0] m_idx;
  logic       m_valid;
  logic       scan_done;

  mux_sel_sequencer #(
    .DATA_WIDTH(3),
    .DWELL_W   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dwell    (dwell),
    .m_in     (m_in),
`ifdef MUX_SEQ_MANUAL_EN
    .mode     (mode),
    .man_sel  (man_sel),
`endif
    .s2       (s2),
    .s1       (s1),
    .s0       (s0),
    .m_out    (m_out),
    .m_idx    (m_idx),
    .m_valid  (m_valid),
    .scan_done(scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case ({s2, s1, s0})
      3'b000:  m_in = 3'd1;
      3'b001:  m_in = 3'd2;
      3'b010:  m_in = 3'd3;
      3'b011:  m_in = 3'd4;
      3'b100:  m_in = 3'd5;
      default: m_in = 3'd7;
    endcase
  end

  typedef struct {
    int cyc;
    int d;
    int i;
    int dn;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   c0;
  int   c1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int d, input int i, input int dn);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    e.i   = i;
    e.dn  = dn;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (m_valid) begin
      if (q.size() == 0) begin
        chk("spurious_strobe", 32'(m_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("m_out", 32'(m_out), 32'(e.d));
        chk("m_idx", 32'(m_idx), 32'(e.i));
        chk("scan_done", 32'(scan_done), 32'(e.dn));
      end
    end else if (scan_done) begin
      chk("done_without_valid", 32'(scan_done), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    chk(tag, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    rst     = 1'b1;
    en      = 1'b0;
    dwell   = 4'd3;
    mode    = 1'b0;
    man_sel = 3'd0;

    // reset then idle
    tick();
    chk("rst_sel", 32'({s2, s1, s0}), 32'd0);
    chk("rst_m_out", 32'(m_out), 32'd0);
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_sel", 32'({s2, s1, s0}), 32'd0);
      chk("idle_m_out", 32'(m_out), 32'd0);
    end
    drain("idle_drain");

    // basic scan, dwell=3, then stop after one more slot
    do_reset();
    dwell = 4'd3;
    en    = 1'b1;
    c0    = cyc;
    for (int k = 0; k < 5; k++) begin
      push(c0 + 5 + 4 * k, k + 1, k, (k == 4) ? 1 : 0);
    end
    push(c0 + 25, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i <= 4) chk("scan_sel_u", 32'({s2, s1, s0}), 32'd0);
      if (i == 5) chk("scan_sel_v", 32'({s2, s1, s0}), 32'd1);
      if (i == 17) chk("scan_sel_y", 32'({s2, s1, s0}), 32'd4);
      if (i == 21) begin
        chk("scan_sel_wrap", 32'({s2, s1, s0}), 32'd0);
        en = 1'b0;
      end
    end
    chk("scan_park_sel", 32'({s2, s1, s0}), 32'd1);
    chk("scan_hold_m_out", 32'(m_out), 32'd1);
    drain("scan_drain");

    // dwell=0 gives a 2-cycle slot
    do_reset();
    dwell = 4'd0;
    en    = 1'b1;
    c0    = cyc;
    for (int k = 0; k < 10; k++) begin
      push(c0 + 3 + 2 * k, (k % 5) + 1, k % 5, ((k % 5) == 4) ? 1 : 0);
    end
    for (int i = 1; i <= 26; i++) begin
      tick();
      if (i == 19) en = 1'b0;
    end
    drain("dwell0_drain");

    // stop during idx=2 settle, then resume
    do_reset();
    dwell = 4'd3;
    en    = 1'b1;
    c0    = cyc;
    push(c0 + 5, 1, 0, 0);
    push(c0 + 9, 2, 1, 0);
    push(c0 + 13, 3, 2, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 10) en = 1'b0;
    end
    chk("stop_sel", 32'({s2, s1, s0}), 32'd3);
    chk("stop_m_out", 32'(m_out), 32'd3);
    drain("stop_drain");
    en = 1'b1;
    c1 = cyc;
    push(c1 + 5, 4, 3, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) en = 1'b0;
    end
    drain("resume_drain");

    // reset during settle of idx=3
    do_reset();
    dwell = 4'd5;
    en    = 1'b1;
    c0    = cyc;
    push(c0 + 7, 1, 0, 0);
    push(c0 + 13, 2, 1, 0);
    push(c0 + 19, 3, 2, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
    end
    drain("pre_abort_drain");
    rst = 1'b1;
    tick();
    chk("abort_sel", 32'({s2, s1, s0}), 32'd0);
    chk("abort_m_out", 32'(m_out), 32'd0);
    chk("abort_valid", 32'(m_valid), 32'd0);
    rst = 1'b0;
    c1  = cyc;
    push(c1 + 7, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 2) en = 1'b0;
    end
    drain("abort_drain");

`ifdef MUX_SEQ_MANUAL_EN
    // manual mode with clamped select, then back to auto
    do_reset();
    dwell   = 4'd1;
    mode    = 1'b1;
    man_sel = 3'd6;
    en      = 1'b1;
    c0      = cyc;
    push(c0 + 3, 5, 4, 1);
    push(c0 + 5, 5, 4, 1);
    push(c0 + 7, 5, 4, 1);
    push(c0 + 9, 1, 0, 0);
    push(c0 + 11, 2, 1, 0);
    push(c0 + 13, 3, 2, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) chk("man_sel_y", 32'({s2, s1, s0}), 32'd4);
      if (i == 5) mode = 1'b0;
      if (i == 12) en = 1'b0;
    end
    drain("manual_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream control stage for the 5-to-1 DATA_WIDTH-bit select mux (select lines s2,s1,s0; sources U,V,W,X,Y; result M). It steps the mux select through all five sources. It holds each select for a programmable settle time, then samples the returned mux result into a registered output with a one-cycle valid strobe. It converts the purely combinational mux into a timed, registered scan path.

Parameters:
DATA_WIDTH, 3, width of mux data returned on m_in and presented on m_out
DWELL_W, 4, width of the dwell (settle-cycle) count input

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  run enable; 1 = scan, 0 = stop after the current slot
dwell  input  DWELL_W  settle cycles per source; 0 treated as 1; sampled on slot entry
m_in  input  DATA_WIDTH  mux result M fed back from the mux
s2  output  1  mux select bit 2, registered
s1  output  1  mux select bit 1, registered
s0  output  1  mux select bit 0, registered
m_out  output  DATA_WIDTH  last sampled mux result, registered
m_idx  output  3  source index (0..4 = U,V,W,X,Y) of the data on m_out
m_valid  output  1  one-cycle strobe: m_out/m_idx updated this cycle
scan_done  output  1  one-cycle strobe, coincident with m_valid when m_idx==4

Behaviour:
- Clock and reset: clk only, single domain. rst is synchronous and active-high, sampled on the clk rising edge; it has priority over everything.
- Reset values: state=IDLE, idx=0, {s2,s1,s0}=000, m_out=0, m_idx=0, m_valid=0, scan_done=0, dwell counter=0.
- Index-to-select map, registered from idx:
  - 0 -> 000 (U)
  - 1 -> 001 (V)
  - 2 -> 010 (W)
  - 3 -> 011 (X)
  - 4 -> 100 (Y)
  - idx never takes the values 5..7.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - Selects hold the current idx.
  - en=1 -> SETTLE next cycle, loading cnt = (dwell==0 ? 1 : dwell).
- SETTLE:
  - cnt decrements each cycle.
  - When cnt==1 -> SAMPLE next cycle.
  - Duration is exactly max(dwell,1) cycles.
- SAMPLE (1 cycle):
  - On the edge ending SAMPLE: m_out<=m_in, m_idx<=idx, m_valid<=1, scan_done<=(idx==4).
  - idx advances: 4 wraps to 0, otherwise +1.
  - Next state is SETTLE (cnt reloaded from current dwell) if en=1, else IDLE.
- Slot period: max(dwell,1)+1 cycles per source. A full scan is 5 slots.
- Select timing: selects change only on the edge leaving SAMPLE. They are stable for every SETTLE and SAMPLE cycle of a slot, so m_in has had at least one full cycle to settle before capture.
- m_valid and scan_done are high for exactly one cycle, visible in the first cycle after SAMPLE. They are 0 in all other cycles.
- en deassert mid-slot: the current slot completes, including its sample and strobe. The block then parks in IDLE with idx already advanced. A later en=1 resumes at that idx; it does not restart from U.
- dwell change mid-slot: ignored until the next slot load.
- rst during SETTLE/SAMPLE: immediate return to reset values next edge. No strobe is issued for the aborted slot.
- m_out holds its value between strobes and while in IDLE.

Optional Feature:
Macro MUX_SEQ_MANUAL_EN.
- Defined: adds input ports mode (1 bit) and man_sel (3 bits).
  - With mode=1, the index loaded at each slot boundary (IDLE exit and SAMPLE exit) is man_sel instead of idx+1.
  - man_sel values 5..7 are clamped to 4.
  - Repeated slots on one source are allowed.
  - scan_done still follows m_idx==4.
- Not defined: the ports are absent and the block always auto-increments with wrap, as above.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, en=0 -> selects 000, m_out=0, m_valid=0 indefinitely; no strobes.
2. Basic scan: dwell=3; m_in driven by a model mux with U..Y = 1,2,3,4,5; en=1 at cycle 0.
   - Select 000 during cycles 1-4; strobe at cycle 5 with m_out=1, m_idx=0; selects 001 from cycle 5.
   - Strobes every 4 cycles with m_out 2,3,4,5; scan_done=1 only with m_out=5; next slot select 000.
3. dwell=0: slot period is 2 cycles. Ten consecutive strobes return 1,2,3,4,5,1,2,3,4,5 at 2-cycle spacing. scan_done fires twice.
4. Stop/resume:
   - Drop en during the SETTLE of idx=2 -> strobe m_out=3 still issued, then IDLE with selects 011.
   - Re-raise en -> next strobe m_out=4, m_idx=3.
5. Reset mid-slot: assert rst in SETTLE of idx=3 (dwell=5) -> next cycle selects 000, m_out=0, no strobe. After release with en=1, the first strobe is m_out=1.
6. With MUX_SEQ_MANUAL_EN:
   - mode=1, man_sel=6 -> every slot uses idx 4 (select 100); strobes m_out=5 with scan_done=1 each slot.
   - mode=0 -> auto scan resumes 0,1,2...
